// File: rtl/uart_tx_periph_if.sv
// uart_tx_periph_if: MCU data-bus slice seen by the UART transmitter.
//   sel      - decoder select for the peripheral's 16-byte window
//   busWe    - write enable for the current bus cycle
//   busAddr  - byte address (peripheral decodes [3:2])
//   busWData - write data
//   wstrb    - byte strobes for writes
//   busRData - combinational read data returned by the peripheral
interface uart_tx_periph_if;
    logic        sel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  wstrb;
    logic [31:0] busRData;

    modport master (
        output sel, busWe, busAddr, busWData, wstrb,
        input  busRData
    );

    modport slave (
        input  sel, busWe, busAddr, busWData, wstrb,
        output busRData
    );
endinterface

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a TX FIFO.
//   clk     - system clock, rising edge
//   reset   - synchronous, active-low reset
//   bus     - bus slave port (select, write enable, address, data, strobes, read data)
//   tx      - serial line, idle high
//   tx_busy - high while a frame is on the line
// Register map (busAddr[3:2]): 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 CTRL.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_periph_if.slave   bus,
    output logic              tx,
    output logic              tx_busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    txState_t         state, nextState;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      baudDiv;
    logic             enable;
    logic [15:0]      curDiv;
    logic [15:0]      baudCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             txReg;

    logic [1:0] regSel;
    logic       wrCycle, pushReq, clearReq, ovfClr, pushOk;
    logic       fifoFull, fifoEmpty, popHead, bitDone;
    logic       unusedBusBits;

    assign regSel        = bus.busAddr[3:2];
    assign wrCycle       = bus.sel & bus.busWe;
    assign pushReq       = wrCycle && (regSel == 2'd0) && bus.wstrb[0];
    assign clearReq      = wrCycle && (regSel == 2'd3) && bus.wstrb[0] && bus.busWData[1];
    assign ovfClr        = wrCycle && (regSel == 2'd1) && bus.wstrb[0] && bus.busWData[3];
    assign fifoFull      = (count == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty     = (count == '0);
    // Fullness is judged before any same-cycle pop; a clear discards the push.
    assign pushOk        = pushReq && !fifoFull && !clearReq;
    assign bitDone       = (baudCnt == curDiv);
    assign unusedBusBits = ^{bus.busAddr[31:4], bus.busAddr[1:0], bus.busWData[31:16]};

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= bus.busWData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (clearReq) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (pushOk) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (popHead) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                count <= count + CNT_W'(pushOk) - CNT_W'(popHead);
            end
            if (ovfClr) begin
                overflow <= 1'b0;
            end else if (pushReq && fifoFull && !clearReq) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            baudDiv <= DEFAULT_DIV;
            enable  <= 1'b1;
        end else if (wrCycle) begin
            if (regSel == 2'd2) begin
                if (bus.wstrb[0]) baudDiv[7:0]  <= bus.busWData[7:0];
                if (bus.wstrb[1]) baudDiv[15:8] <= bus.busWData[15:8];
            end
            if (regSel == 2'd3 && bus.wstrb[0]) begin
                enable <= bus.busWData[0];
            end
        end
    end

    always_comb begin
        bus.busRData = '0;
        if (bus.sel) begin
            case (regSel)
                2'd1: begin
                    bus.busRData[0]   = fifoEmpty;
                    bus.busRData[1]   = fifoFull;
                    bus.busRData[2]   = tx_busy;
                    bus.busRData[3]   = overflow;
                    bus.busRData[7:4] = 4'(count);
                end
                2'd2:    bus.busRData[15:0] = baudDiv;
                2'd3:    bus.busRData[0]    = enable;
                default: bus.busRData       = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        popHead   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifoEmpty) begin
                    popHead   = 1'b1;
                    nextState = START;
                end
            end
            START: if (bitDone) nextState = DATA;
            DATA:  if (bitDone && bitCnt == 3'd7) nextState = STOP;
            STOP:  if (bitDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The divisor is re-sampled at every bit boundary so a BAUDDIV write
    // never stretches or shortens the bit currently on the line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            baudCnt  <= '0;
            bitCnt   <= '0;
            curDiv   <= DEFAULT_DIV;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            case (state)
                START:   txReg <= 1'b0;
                DATA:    txReg <= shiftReg[0];
                default: txReg <= 1'b1;
            endcase
            if (state == IDLE) begin
                baudCnt <= '0;
                bitCnt  <= '0;
                if (popHead) begin
                    shiftReg <= mem[rdPtr];
                    curDiv   <= baudDiv;
                end
            end else if (bitDone) begin
                baudCnt <= '0;
                curDiv  <= baudDiv;
                if (state == DATA) begin
                    shiftReg <= shiftReg >> 1;
                    bitCnt   <= bitCnt + 3'd1;
                end
            end else begin
                baudCnt <= baudCnt + 16'd1;
            end
        end
    end

    // tx is registered from the state, so the line trails tx_busy by one clock.
    assign tx      = txReg;
    assign tx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed + randomized bench for uart_tx_periph.
// Expected line waveforms are built from bit durations and byte values.
module tb_uart_tx_periph;
    logic clk = 1'b0;
    logic reset;
    logic tx, txBusy;
    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    int   durs[10];
    byte unsigned modelQ[$];
    bit   modelOvf;

    uart_tx_periph_if busIf();

    uart_tx_periph #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
        .clk(clk), .reset(reset), .bus(busIf.slave), .tx(tx), .tx_busy(txBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic busIdle();
        busIf.sel = 1'b0; busIf.busWe = 1'b0; busIf.wstrb = 4'b0;
        busIf.busAddr = '0; busIf.busWData = '0;
    endtask

    task automatic busDrive(input logic [1:0] regIdx, input logic [31:0] data,
                            input logic [3:0] strb, input logic selVal);
        busIf.sel = selVal; busIf.busWe = 1'b1; busIf.wstrb = strb;
        busIf.busAddr = {28'h0, regIdx, 2'b00}; busIf.busWData = data;
    endtask

    task automatic busWrite(input logic [1:0] regIdx, input logic [31:0] data,
                            input logic [3:0] strb, input logic selVal);
        busDrive(regIdx, data, strb, selVal);
        tick();
        busIdle();
    endtask

    task automatic busRead(input logic [1:0] regIdx, input logic selVal, output logic [31:0] val);
        busIf.sel = selVal; busIf.busWe = 1'b0; busIf.wstrb = 4'b0;
        busIf.busAddr = {28'h0, regIdx, 2'b00};
        #1;
        val = busIf.busRData;
        busIdle();
    endtask

    function automatic logic [31:0] expStatus(input int cnt, input bit ovf, input bit busy);
        return 32'(cnt * 16 + (ovf ? 8 : 0) + (busy ? 4 : 0) + (cnt == 8 ? 2 : 0) + (cnt == 0 ? 1 : 0));
    endfunction

    task automatic chkReg(input string tag, input logic [1:0] regIdx, input logic [31:0] exp);
        logic [31:0] v;
        busRead(regIdx, 1'b1, v);
        chk(tag, v, exp);
    endtask

    task automatic setDurs(input int div);
        for (int i = 0; i < 10; i++) durs[i] = div + 1;
    endtask

    // Entered with the start bit on the line (sample 0); leaves on the last stop sample.
    task automatic checkFrame(input string tag, input logic [7:0] data, input int modK,
                              input logic [15:0] modDiv, output int busyCnt);
        int total, mism, idx, acc;
        logic [7:0] decoded;
        logic expBit;
        total = 0;
        for (int i = 0; i < 10; i++) total += durs[i];
        mism = 0; busyCnt = 0; decoded = '0;
        for (int k = 0; k < total; k++) begin
            if (k > 0) tick();
            if (k == modK + 1) busIdle();
            acc = 0; idx = 0;
            while (k >= acc + durs[idx]) begin
                acc += durs[idx];
                idx++;
            end
            expBit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : data[idx-1];
            if (tx !== expBit) mism++;
            if (idx >= 1 && idx <= 8 && k == acc + durs[idx] / 2) decoded[idx-1] = tx;
            if (txBusy === 1'b1) busyCnt++;
            if (k == modK) busDrive(2'd2, {16'h0, modDiv}, 4'b0011, 1'b1);
        end
        chk({tag, " byte"}, {24'h0, decoded}, {24'h0, data});
        chk({tag, " waveform mismatches"}, mism, 0);
    endtask

    task automatic waitFall(input string tag, input int budget);
        for (int i = 0; i < budget && tx !== 1'b0; i++) tick();
        chk({tag, " start bit seen"}, {31'h0, tx === 1'b0}, 32'd1);
    endtask

    task automatic quietLine(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx !== 1'b1 || txBusy !== 1'b0) bad++;
        end
        chk({tag, " line idle"}, bad, 0);
    endtask

    task automatic sendOne(input string tag, input logic [7:0] data, input int div);
        int busyCnt;
        busWrite(2'd0, {24'h0, data}, 4'b0001, 1'b1);
        tick();
        chk({tag, " tx still high 1 clk after write"}, {31'h0, tx}, 32'd1);
        chk({tag, " busy 1 clk after write"}, {31'h0, txBusy}, 32'd1);
        tick();
        chk({tag, " tx low 2 clks after write"}, {31'h0, tx}, 32'd0);
        setDurs(div);
        checkFrame(tag, data, -10, 16'h0, busyCnt);
        chk({tag, " busy length"}, busyCnt + 1, 10 * (div + 1));
        tick();
        chk({tag, " idle after frame"}, {30'h0, tx, txBusy}, 32'b10);
    endtask

    initial begin
        int busyCnt, div, c0, n;
        logic [7:0] d;
        logic [31:0] v;
        busIdle();
        reset = 1'b0;

        // Reset state
        tick(); tick();
        reset = 1'b1;
        chk("reset tx", {31'h0, tx}, 32'd1);
        chk("reset busy", {31'h0, txBusy}, 32'd0);
        chkReg("reset STATUS", 2'd1, 32'h0000_0001);
        chkReg("reset BAUDDIV", 2'd2, 32'h0000_0363);
        chkReg("reset CTRL", 2'd3, 32'h0000_0001);

        // Single byte 0xA5 at BAUDDIV=3
        busWrite(2'd2, 32'd3, 4'b0011, 1'b1);
        sendOne("A5", 8'hA5, 3);

        // Randomized single bytes and divisors, including BAUDDIV=0
        for (int it = 0; it < 6; it++) begin
            div = (it == 0) ? 0 : int'($urandom_range(0, 5));
            d = 8'($urandom_range(0, 255));
            busWrite(2'd2, 32'(div), 4'b0011, 1'b1);
            sendOne($sformatf("rand%0d", it), d, div);
        end

        // Overflow with transmitter disabled
        div = int'($urandom_range(0, 2));
        busWrite(2'd2, 32'(div), 4'b0011, 1'b1);
        busWrite(2'd3, 32'h0, 4'b0001, 1'b1);
        modelQ.delete();
        modelOvf = 0;
        for (int i = 1; i <= 9; i++) begin
            busWrite(2'd0, 32'(i), 4'b0001, 1'b1);
            if (modelQ.size() < 8) modelQ.push_back(8'(i));
            else modelOvf = 1;
        end
        chkReg("overflow STATUS", 2'd1, expStatus(modelQ.size(), modelOvf, 0));
        quietLine("disabled", 20);
        busWrite(2'd1, 32'h8, 4'b0001, 1'b1);
        modelOvf = 0;
        chkReg("overflow cleared STATUS", 2'd1, expStatus(modelQ.size(), modelOvf, 0));
        busWrite(2'd3, 32'h1, 4'b0001, 1'b1);
        waitFall("burst", 10);
        setDurs(div);
        n = 0;
        while (modelQ.size() > 0) begin
            d = modelQ.pop_front();
            checkFrame($sformatf("burst%0d", n), d, -10, 16'h0, busyCnt);
            chk($sformatf("burst%0d busy in window", n), busyCnt, 10 * (div + 1) - 1);
            tick();
            chk($sformatf("burst%0d gap high", n), {31'h0, tx}, 32'd1);
            if (modelQ.size() > 0) begin
                tick();
                chk($sformatf("burst%0d next start", n), {31'h0, tx}, 32'd0);
            end
            n++;
        end
        quietLine("no ninth byte", 30 * (div + 1));
        chkReg("burst done STATUS", 2'd1, expStatus(0, 0, 0));

        // Mid-frame BAUDDIV change during data bit 2 (0xFF, then a random byte)
        for (int it = 0; it < 2; it++) begin
            d = (it == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            busWrite(2'd2, 32'd3, 4'b0011, 1'b1);
            busWrite(2'd0, {24'h0, d}, 4'b0001, 1'b1);
            tick(); tick();
            for (int i = 0; i < 10; i++) durs[i] = (i < 4) ? 4 : 2;
            checkFrame($sformatf("divchg%0d", it), d, 13, 16'd1, busyCnt);
            chk($sformatf("divchg%0d busy length", it), busyCnt + 1, 28);
            chkReg($sformatf("divchg%0d BAUDDIV", it), 2'd2, 32'd1);
            tick();
        end
        busWrite(2'd2, 32'd3, 4'b0011, 1'b1);

        // Disable mid-frame, then fifo_clear with 3 bytes queued
        busWrite(2'd0, 32'h3C, 4'b0001, 1'b1);
        c0 = cyc;
        busWrite(2'd0, 32'h11, 4'b0001, 1'b1);
        busWrite(2'd0, 32'h22, 4'b0001, 1'b1);
        busWrite(2'd0, 32'h33, 4'b0001, 1'b1);
        busWrite(2'd3, 32'h0, 4'b0001, 1'b1);
        chkReg("disabled midframe STATUS", 2'd1, expStatus(3, 0, 1));
        busWrite(2'd3, 32'h2, 4'b0001, 1'b1);
        chkReg("after clear STATUS", 2'd1, expStatus(0, 0, 1));
        chkReg("after clear CTRL", 2'd3, 32'h0);
        for (int i = 0; i < 100 && txBusy !== 1'b0; i++) tick();
        chk("frame completes after disable", cyc - c0, 41);
        quietLine("no frame after clear", 60);
        chkReg("cleared idle STATUS", 2'd1, expStatus(0, 0, 0));
        busWrite(2'd3, 32'h1, 4'b0001, 1'b1);
        quietLine("re-enabled empty", 20);

        // Reset mid-frame
        busWrite(2'd0, 32'h00, 4'b0001, 1'b1);
        tick(); tick();
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset tx low", {31'h0, tx}, 32'd0);
        reset = 1'b0;
        tick();
        chk("midframe reset tx", {31'h0, tx}, 32'd1);
        chk("midframe reset busy", {31'h0, txBusy}, 32'd0);
        reset = 1'b1;
        chkReg("post-reset STATUS", 2'd1, 32'h1);
        chkReg("post-reset BAUDDIV", 2'd2, 32'h363);
        chkReg("post-reset CTRL", 2'd3, 32'h1);
        quietLine("post-reset", 30);

        // Strobes and select
        busWrite(2'd2, 32'd2, 4'b0011, 1'b1);
        busWrite(2'd0, 32'h55, 4'b0010, 1'b1);
        chkReg("wrong strobe STATUS", 2'd1, 32'h1);
        quietLine("wrong strobe", 10);
        busWrite(2'd0, 32'h55, 4'b0001, 1'b0);
        chkReg("no select STATUS", 2'd1, 32'h1);
        quietLine("no select", 10);
        busRead(2'd1, 1'b0, v);
        chk("read sel=0", v, 32'h0);
        busRead(2'd2, 1'b0, v);
        chk("read sel=0 BAUDDIV", v, 32'h0);
        busWrite(2'd2, 32'hABCD_1234, 4'b0010, 1'b1);
        chkReg("BAUDDIV byte1 strobe", 2'd2, 32'h1202);
        busWrite(2'd2, 32'hFFFF_FFFF, 4'b1100, 1'b1);
        chkReg("BAUDDIV upper strobes", 2'd2, 32'h1202);
        chkReg("TXDATA reads 0", 2'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
